// File: rtl/inst_fetch_arbiter.sv
// Fetch sequencer and read-port arbiter for the instruction memory.
// Owns the PC, lends the port to debug reads, halts on a bad fetch.
module inst_fetch_arbiter #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          MEM_BYTES  = 16,
   parameter int          STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   input  logic        dbg_req,
   input  logic [63:0] dbg_addr,
   input  logic [31:0] instruction,
   output logic [63:0] Inst_Address,
   output logic [31:0] instr_out,
   output logic [63:0] pc_out,
   output logic        instr_valid,
   output logic        dbg_grant,
   output logic [31:0] dbg_data,
   output logic        dbg_valid,
   output logic        fault
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   localparam logic [63:0] LAST_PC    = 64'(MEM_BYTES - 4);
   localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);

   state_t      state;
   logic [63:0] pc;
   logic [2:0]  starve_cnt;
   logic        running;
   logic        starved;
   logic        illegal;
   logic        fetch_owns;

   assign running    = (state == RUN);
   assign starved    = (starve_cnt == STARVE_LIM);
   assign dbg_grant  = dbg_req & ~reset & (~running | stall | starved);
   assign Inst_Address = dbg_grant ? dbg_addr : pc;
   assign illegal    = (pc[1:0] != 2'b00) | (pc > LAST_PC);
   assign fetch_owns = running & ~dbg_grant;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         starve_cnt  <= 3'd0;
         instr_out   <= 32'd0;
         pc_out      <= 64'd0;
         instr_valid <= 1'b0;
         dbg_data    <= 32'd0;
         dbg_valid   <= 1'b0;
         fault       <= 1'b0;
      end else begin
         dbg_valid   <= dbg_grant;
         instr_valid <= 1'b0;
         if (dbg_grant)
            dbg_data <= instruction;

         // Only denied RUN requests age; any grant or idle request resets.
         if (running && dbg_req && !dbg_grant) begin
            if (!starved)
               starve_cnt <= starve_cnt + 3'd1;
         end else begin
            starve_cnt <= 3'd0;
         end

         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  pc    <= RESET_PC;
               end
            end
            RUN: begin
               if (fetch_owns && illegal) begin
                  fault <= 1'b1;
                  state <= HALT;
               end else if (branch_taken) begin
                  pc <= branch_target;
               end else if (!stall && !dbg_grant) begin
                  instr_out   <= instruction;
                  pc_out      <= pc;
                  instr_valid <= 1'b1;
                  pc          <= pc + 64'd4;
               end
            end
            HALT: begin
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Scoreboard bench for inst_fetch_arbiter: directed cases plus random
// traffic checked against a transaction-level reference model.
module tb_inst_fetch_arbiter;

   localparam logic [63:0] RESET_PC   = 64'h0;
   localparam int          MEM_BYTES  = 16;
   localparam int          STARVE_MAX = 4;

   localparam logic [31:0] IMG [4] = '{
      32'h02853483, 32'h009A84B3, 32'h00148493, 32'h02953423
   };

   typedef struct {
      int          tag;
      logic [63:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_target = 64'd0;
   logic        dbg_req = 1'b0;
   logic [63:0] dbg_addr = 64'd0;
   logic [31:0] instruction;
   logic [63:0] Inst_Address;
   logic [31:0] instr_out;
   logic [63:0] pc_out;
   logic        instr_valid;
   logic        dbg_grant;
   logic [31:0] dbg_data;
   logic        dbg_valid;
   logic        fault;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   mon_en = 0;
   exp_t instq[$];
   exp_t dbgq[$];

   // reference model state
   bit          m_run;
   bit          m_halt;
   logic [63:0] m_pc;
   int          m_wait;
   logic        exp_fault = 1'b0;

   inst_fetch_arbiter #(
      .RESET_PC  (RESET_PC),
      .MEM_BYTES (MEM_BYTES),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .dbg_req      (dbg_req),
      .dbg_addr     (dbg_addr),
      .instruction  (instruction),
      .Inst_Address (Inst_Address),
      .instr_out    (instr_out),
      .pc_out       (pc_out),
      .instr_valid  (instr_valid),
      .dbg_grant    (dbg_grant),
      .dbg_data     (dbg_data),
      .dbg_valid    (dbg_valid),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem_byte(input logic [63:0] a);
      int          k;
      logic [31:0] w;
      k = int'(a % 64'(MEM_BYTES));
      w = IMG[k / 4];
      return w[8 * (k % 4) +: 8];
   endfunction

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {mem_byte(a + 64'd3), mem_byte(a + 64'd2),
              mem_byte(a + 64'd1), mem_byte(a)};
   endfunction

   assign instruction = mem_word(Inst_Address);

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // One clock of stimulus; the model decides grant and outcomes.
   task automatic step(input logic r, input logic s, input logic stl,
                       input logic br, input logic [63:0] tgt,
                       input logic dq, input logic [63:0] da,
                       output logic g);
      bit   legal;
      exp_t e;
      @(negedge clk);
      reset = r;
      start = s;
      stall = stl;
      branch_taken = br;
      branch_target = tgt;
      dbg_req = dq;
      dbg_addr = da;
      #1;
      g = 1'b0;
      if (r) begin
         m_run = 0;
         m_halt = 0;
         m_pc = RESET_PC;
         m_wait = 0;
         exp_fault = 1'b0;
         chk("grant_in_reset", {63'd0, dbg_grant}, 64'd0);
      end else begin
         g = dq && (!m_run || stl || m_wait == STARVE_MAX);
         chk("dbg_grant", {63'd0, dbg_grant}, {63'd0, g});
         chk("inst_address", Inst_Address, g ? da : m_pc);
         if (g) begin
            e.tag = cyc + 1;
            e.pc = da;
            e.data = mem_word(da);
            dbgq.push_back(e);
         end
         if (m_run) begin
            legal = (m_pc % 64'd4 == 64'd0) &&
                    (64'(MEM_BYTES - 4) >= m_pc);
            if (!g && !legal) begin
               exp_fault = 1'b1;
               m_run = 0;
               m_halt = 1;
            end else if (br) begin
               m_pc = tgt;
            end else if (!stl && !g) begin
               e.tag = cyc + 1;
               e.pc = m_pc;
               e.data = mem_word(m_pc);
               instq.push_back(e);
               m_pc = m_pc + 64'd4;
            end
            if (dq && !g)
               m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : m_wait;
            else
               m_wait = 0;
         end else begin
            m_wait = 0;
            if (!m_halt && s) begin
               m_run = 1;
               m_pc = RESET_PC;
            end
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      logic g;
      for (int i = 0; i < n; i++)
         step(0, 0, 0, 0, 64'd0, 0, 64'd0, g);
   endtask

   task automatic check_reset_outputs();
      @(posedge clk);
      #2;
      chk("rst_instr_out", {32'd0, instr_out}, 64'd0);
      chk("rst_pc_out", pc_out, 64'd0);
      chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
      chk("rst_dbg_valid", {63'd0, dbg_valid}, 64'd0);
      chk("rst_dbg_data", {32'd0, dbg_data}, 64'd0);
      chk("rst_fault", {63'd0, fault}, 64'd0);
      chk("rst_address", Inst_Address, RESET_PC);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a word.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (instr_valid === 1'b1) begin
               if (instq.size() == 0) begin
                  chk("instr_unexpected", {63'd0, instr_valid}, 64'd0);
               end else begin
                  e = instq.pop_front();
                  chk("instr_cycle", 64'(cyc), 64'(e.tag));
                  chk("pc_out", pc_out, e.pc);
                  chk("instr_out", {32'd0, instr_out}, {32'd0, e.data});
               end
            end else if (instq.size() > 0 && instq[0].tag <= cyc) begin
               void'(instq.pop_front());
               chk("instr_missing", {63'd0, instr_valid}, 64'd1);
            end
            if (dbg_valid === 1'b1) begin
               if (dbgq.size() == 0) begin
                  chk("dbg_unexpected", {63'd0, dbg_valid}, 64'd0);
               end else begin
                  e = dbgq.pop_front();
                  chk("dbg_cycle", 64'(cyc), 64'(e.tag));
                  chk("dbg_data", {32'd0, dbg_data}, {32'd0, e.data});
               end
            end else if (dbgq.size() > 0 && dbgq[0].tag <= cyc) begin
               void'(dbgq.pop_front());
               chk("dbg_missing", {63'd0, dbg_valid}, 64'd1);
            end
            chk("fault", {63'd0, fault}, {63'd0, exp_fault});
         end
      end
   end

   initial begin
      logic        g;
      logic        hold;
      logic [63:0] haddr;
      logic        r, s, stl, br;
      logic [63:0] tgt;
      int          n;

      // reset values and debug service in IDLE
      step(1, 0, 0, 0, 64'd0, 0, 64'd0, g);
      mon_en = 1;
      check_reset_outputs();
      step(0, 0, 0, 0, 64'd0, 1, 64'd8, g);
      chk("idle_grant_same_cycle", {63'd0, g}, 64'd1);
      idle_cycles(2);

      // straight-line fetch to the end of memory, then fault, then HALT debug
      step(0, 1, 0, 0, 64'd0, 0, 64'd0, g);
      idle_cycles(7);
      chk("halt_fault", {63'd0, fault}, 64'd1);
      step(0, 0, 0, 1, 64'd0, 1, 64'd4, g);
      idle_cycles(2);

      // stall for three cycles after the pc-4 fetch
      step(1, 0, 0, 0, 64'd0, 0, 64'd0, g);
      step(0, 1, 0, 0, 64'd0, 0, 64'd0, g);
      idle_cycles(2);
      for (int i = 0; i < 3; i++)
         step(0, 0, 1, 0, 64'd0, 0, 64'd0, g);
      idle_cycles(4);

      // branch under stall to 12, then a misaligned target
      step(1, 0, 0, 0, 64'd0, 0, 64'd0, g);
      step(0, 1, 0, 0, 64'd0, 0, 64'd0, g);
      idle_cycles(1);
      step(0, 0, 1, 1, 64'd12, 0, 64'd0, g);
      idle_cycles(3);
      step(1, 0, 0, 0, 64'd0, 0, 64'd0, g);
      step(0, 1, 0, 0, 64'd0, 0, 64'd0, g);
      step(0, 0, 0, 1, 64'd6, 0, 64'd0, g);
      idle_cycles(3);

      // starvation steal: grant on the 5th requested RUN cycle
      step(1, 0, 0, 0, 64'd0, 0, 64'd0, g);
      step(0, 1, 0, 0, 64'd0, 0, 64'd0, g);
      n = 0;
      g = 1'b0;
      while (!g && n < 20) begin
         step(0, 0, 0, 0, 64'd0, 1, 64'd4, g);
         n++;
      end
      chk("starve_wait", 64'(n), 64'(STARVE_MAX + 1));
      idle_cycles(4);

      // reset lands on the cycle a grant would have been issued
      step(1, 0, 0, 0, 64'd0, 0, 64'd0, g);
      step(0, 1, 0, 0, 64'd0, 0, 64'd0, g);
      idle_cycles(2);
      step(1, 0, 1, 0, 64'd0, 1, 64'd8, g);
      check_reset_outputs();

      // random traffic
      hold = 1'b0;
      haddr = 64'd0;
      for (int ep = 0; ep < 40; ep++) begin
         step(1, 0, 0, 0, 64'd0, 0, 64'd0, g);
         for (int c = 0; c < 70; c++) begin
            if (!hold && $urandom_range(0, 99) < 20) begin
               hold = 1'b1;
               haddr = 64'($urandom_range(0, 15));
               if ($urandom_range(0, 1) == 0)
                  haddr = haddr & ~64'd3;
            end
            r   = ($urandom_range(0, 99) < 1);
            s   = ($urandom_range(0, 3) == 0);
            stl = ($urandom_range(0, 99) < 25);
            br  = ($urandom_range(0, 99) < 8);
            tgt = 64'($urandom_range(0, 4) * 4);
            if ($urandom_range(0, 99) < 15)
               tgt = 64'($urandom_range(0, 20));
            step(r, s, stl, br, tgt, hold, haddr, g);
            if (g)
               hold = 1'b0;
         end
      end

      step(1, 0, 0, 0, 64'd0, 0, 64'd0, g);
      idle_cycles(3);
      chk("instq_drained", 64'(instq.size()), 64'd0);
      chk("dbgq_drained", 64'(dbgq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
